// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared unit codes, payload layout and dispatch FSM states for the OoO front end
package ooo_pkg;

    localparam int PAYLOAD_W        = 303;
    localparam int FUNC_UNIT_CODE_W = 3;

    localparam logic [2:0] FX_UNIT_ID     = 3'd0;
    localparam logic [2:0] FP_UNIT_ID     = 3'd1;
    localparam logic [2:0] VX_UNIT_ID     = 3'd2;
    localparam logic [2:0] CR_UNIT_ID     = 3'd3;
    localparam logic [2:0] LS_UNIT_ID     = 3'd4;
    localparam logic [2:0] BRANCH_UNIT_ID = 3'd6;

    // Codes 5 and 7 have no reservation station behind them.
    localparam logic [7:0] LEGAL_UNIT_MASK = 8'b0101_1111;

    typedef struct packed {
        logic [3:0]   instFormat;
        logic [9:0]   opcode;
        logic [5:0]   rd;
        logic [5:0]   rs1;
        logic [5:0]   rs2;
        logic [5:0]   rs3;
        logic [63:0]  imm;
        logic [63:0]  pc;
        logic [136:0] body;
    } payload_t;

    typedef enum logic {
        DISPATCH_RUN,
        DISPATCH_DRAIN
    } dispatch_state_t;

    function automatic logic legal_unit(input logic [2:0] code,
                                        input logic [7:0] mask = LEGAL_UNIT_MASK);
        return mask[code];
    endfunction

endpackage

// File: rtl/ioq_dispatch_reader_if.sv
// rtl/ioq_dispatch_reader_if.sv - queue read port plus per-unit dispatch bus of the in-order queue reader
interface ioq_dispatch_reader_if #(
    parameter int PAYLOAD_W = 303,
    parameter int CODE_W    = 3
);
    logic                     isEmpty_i;
    logic                     readEnable_o;
    logic [PAYLOAD_W-1:0]     payload_i;
    logic [CODE_W-1:0]        funcUnitType_i;
    logic                     flush_i;
    logic [(1<<CODE_W)-1:0]   unitReady_i;
    logic [(1<<CODE_W)-1:0]   unitValid_o;
    logic [PAYLOAD_W-1:0]     payload_o;
    logic                     badUnit_o;

    modport master (
        input  isEmpty_i, payload_i, funcUnitType_i, flush_i, unitReady_i,
        output readEnable_o, unitValid_o, payload_o, badUnit_o
    );

    modport slave (
        output isEmpty_i, payload_i, funcUnitType_i, flush_i, unitReady_i,
        input  readEnable_o, unitValid_o, payload_o, badUnit_o
    );

endinterface

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - generic 2-entry FIFO with push/pop/flush and occupancy
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head_data
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic [1:0]   occ_q;
    logic         wr_ptr;

    // With occ==2 the write slot aliases the head, which is only legal alongside a pop.
    assign wr_ptr = rd_ptr_q ^ occ_q[0];

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= push_data;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/ioq_dispatch_reader.sv
// rtl/ioq_dispatch_reader.sv - in-order queue reader dispatching to FU reservation stations
// Optional statistics and illegal-code logging with IOQ_DISPATCH_STATS_EN.
module ioq_dispatch_reader #(
    parameter int PAYLOAD_W        = ooo_pkg::PAYLOAD_W,
    parameter int funcUnitCodeSize = ooo_pkg::FUNC_UNIT_CODE_W,
    parameter int FXUnitId         = 0,
    parameter int FPUnitId         = 1,
    parameter int VXUnitId         = 2,
    parameter int CRUnitId         = 3,
    parameter int LSUnitId         = 4,
    parameter int BranchUnitID     = 6
`ifdef IOQ_DISPATCH_STATS_EN
    , parameter int statsWidth     = 32
`endif
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    ioq_dispatch_reader_if.master bus
`ifdef IOQ_DISPATCH_STATS_EN
    , output logic [statsWidth-1:0] dispatchCount_o
`endif
);
    import ooo_pkg::*;

    localparam int         ENTRY_W   = PAYLOAD_W + funcUnitCodeSize;
    localparam logic [7:0] UNIT_MASK = 8'((1 << FXUnitId) | (1 << FPUnitId) | (1 << VXUnitId) |
                                          (1 << CRUnitId) | (1 << LSUnitId) | (1 << BranchUnitID));

    dispatch_state_t             state_q, state_d;
    logic                        inflight_q;
    logic [1:0]                  occ;
    logic [ENTRY_W-1:0]          head_entry;
    logic [funcUnitCodeSize-1:0] head_code;
    logic                        has_head;
    logic                        head_legal;
    logic                        blocked;
    logic                        dispatch_fire;
    logic                        drop;
    logic                        pop;
    logic                        push;
    logic                        read_en;
    logic [7:0]                  unit_valid;

    assign head_code  = head_entry[ENTRY_W-1 -: funcUnitCodeSize];
    assign has_head   = (occ != 2'd0);
    assign head_legal = legal_unit(head_code, UNIT_MASK);
    assign blocked    = bus.flush_i | (state_q == DISPATCH_DRAIN);

    // The entry returning from the queue is discarded on a flush and throughout DRAIN.
    assign push = inflight_q & ~bus.flush_i & (state_q == DISPATCH_RUN);

    always_comb begin
        state_d       = state_q;
        unit_valid    = '0;
        dispatch_fire = 1'b0;
        drop          = 1'b0;
        pop           = 1'b0;
        read_en       = 1'b0;

        if (has_head && !blocked) begin
            if (head_legal) begin
                unit_valid[head_code] = 1'b1;
                dispatch_fire         = bus.unitReady_i[head_code];
            end else begin
                drop = 1'b1;
            end
        end
        pop = dispatch_fire | drop;

        // Never let buffered + in-flight exceed the two skid slots.
        read_en = reset_i && (state_q == DISPATCH_RUN) && !bus.flush_i && !bus.isEmpty_i &&
                  (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

        case (state_q)
            DISPATCH_RUN:   if (bus.flush_i && (inflight_q || read_en)) state_d = DISPATCH_DRAIN;
            DISPATCH_DRAIN: state_d = DISPATCH_RUN;
            default:        state_d = DISPATCH_RUN;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= DISPATCH_RUN;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= read_en;
        end
    end

    skid_fifo2 #(
        .W (ENTRY_W)
    ) u_skid (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .flush     (bus.flush_i),
        .push      (push),
        .push_data ({bus.funcUnitType_i, bus.payload_i}),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_entry)
    );

    assign bus.readEnable_o = read_en;
    assign bus.unitValid_o  = unit_valid;
    assign bus.payload_o    = head_entry[PAYLOAD_W-1:0];
    assign bus.badUnit_o    = drop;

`ifdef IOQ_DISPATCH_STATS_EN
    logic [statsWidth-1:0] dispatch_count_q;
    logic [statsWidth-1:0] unit_count_q [8];

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            dispatch_count_q <= '0;
            for (int i = 0; i < 8; i++) begin
                unit_count_q[i] <= '0;
            end
        end else if (dispatch_fire) begin
            dispatch_count_q        <= dispatch_count_q + statsWidth'(1);
            unit_count_q[head_code] <= unit_count_q[head_code] + statsWidth'(1);
        end
    end

    assign dispatchCount_o = dispatch_count_q;

    always @(posedge clock_i) begin
        if (reset_i && drop) begin
            $display("[ioq_dispatch_reader] dropped entry with illegal unit code %0d at %0t", head_code, $time);
        end
    end
`endif

endmodule

// File: tb/tb_ioq_dispatch_reader.sv
// tb/tb_ioq_dispatch_reader.sv - directed self-checking bench for ioq_dispatch_reader (optionally IOQ_DISPATCH_STATS_EN)
module tb_ioq_dispatch_reader;
    import ooo_pkg::*;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clock_i = ~clock_i;

    ioq_dispatch_reader_if #(.PAYLOAD_W(PAYLOAD_W), .CODE_W(3)) dif ();

`ifdef IOQ_DISPATCH_STATS_EN
    logic [31:0] dispatch_count;
`endif

    ioq_dispatch_reader dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .bus             (dif)
`ifdef IOQ_DISPATCH_STATS_EN
        , .dispatchCount_o (dispatch_count)
`endif
    );

    int                    tests_run = 0;
    int                    fails     = 0;
    logic                  s_re, s_bad;
    logic [7:0]            s_uv;
    logic [PAYLOAD_W-1:0]  s_pay;
    bit                    force_empty = 1'b0;
    logic [2:0]            q_code [$];
    logic [PAYLOAD_W-1:0]  q_pay  [$];

    function automatic logic [PAYLOAD_W-1:0] mkpay(input int n);
        logic [31:0] w;
        w = 32'(n) * 32'h9E37_79B9 + 32'h1234_5678;
        return {15'(n), {9{w}}};
    endfunction

    task automatic push_q(input logic [2:0] code, input int id);
        q_code.push_back(code);
        q_pay.push_back(mkpay(id));
        dif.isEmpty_i = force_empty || (q_code.size() == 0);
    endtask

    // Sample the current cycle mid-period, then play the registered queue read port one edge later.
    task automatic cyc();
        @(negedge clock_i);
        s_re  = dif.readEnable_o;
        s_uv  = dif.unitValid_o;
        s_bad = dif.badUnit_o;
        s_pay = dif.payload_o;
        @(posedge clock_i);
        #1;
        if (s_re && q_code.size() > 0) begin
            dif.funcUnitType_i = q_code.pop_front();
            dif.payload_i      = q_pay.pop_front();
        end
        dif.isEmpty_i = force_empty || (q_code.size() == 0);
    endtask

    task automatic test_reset();
        dif.unitReady_i = 8'hFF;
        push_q(3'd0, 99);
        repeat (2) @(posedge clock_i);
        #1;
        tests_run++; if (dif.readEnable_o !== 1'b0) begin fails++; $display("FAIL reset readEnable: got %b want 0", dif.readEnable_o); end
        tests_run++; if (dif.unitValid_o !== 8'h00) begin fails++; $display("FAIL reset unitValid: got %h want 00", dif.unitValid_o); end
        tests_run++; if (dif.badUnit_o !== 1'b0) begin fails++; $display("FAIL reset badUnit: got %b want 0", dif.badUnit_o); end
        tests_run++; if (dif.payload_o !== '0) begin fails++; $display("FAIL reset payload: got %h want 0", dif.payload_o); end
`ifdef IOQ_DISPATCH_STATS_EN
        tests_run++; if (dispatch_count !== 32'd0) begin fails++; $display("FAIL reset dispatchCount: got %0d want 0", dispatch_count); end
`endif
        q_code.delete(); q_pay.delete();
        dif.isEmpty_i = 1'b1;
        reset_i = 1'b1;
        cyc();
        tests_run++; if (s_re !== 1'b0 || s_uv !== 8'h00) begin fails++; $display("FAIL reset idle: got re=%b uv=%h want re=0 uv=00", s_re, s_uv); end
    endtask

    task automatic test_in_order();
        bit         e_re [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [7:0] e_uv [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h10, 8'h40, 8'h00};
        int         e_id [7] = '{0, 0, 1, 2, 3, 4, 0};
        dif.unitReady_i = 8'hFF;
        push_q(3'd0, 1); push_q(3'd1, 2); push_q(3'd4, 3); push_q(3'd6, 4);
        for (int c = 0; c < 7; c++) begin
            cyc();
            tests_run++; if (s_re !== e_re[c]) begin fails++; $display("FAIL in_order re cycle %0d: got %b want %b", c + 1, s_re, e_re[c]); end
            tests_run++; if (s_uv !== e_uv[c]) begin fails++; $display("FAIL in_order uv cycle %0d: got %h want %h", c + 1, s_uv, e_uv[c]); end
            if (e_uv[c] != 8'h00) begin
                tests_run++; if (s_pay !== mkpay(e_id[c])) begin fails++; $display("FAIL in_order payload cycle %0d: got %h want %h", c + 1, s_pay, mkpay(e_id[c])); end
            end
        end
    endtask

    task automatic test_stall();
        bit         e_re [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic [7:0] e_uv [11] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h10, 8'h00};
        int         e_id [11] = '{0, 0, 5, 5, 5, 5, 5, 5, 6, 7, 0};
        push_q(3'd1, 5); push_q(3'd0, 6); push_q(3'd4, 7);
        for (int c = 0; c < 11; c++) begin
            dif.unitReady_i = (c < 7) ? 8'hFD : 8'hFF;
            cyc();
            tests_run++; if (s_re !== e_re[c]) begin fails++; $display("FAIL stall re cycle %0d: got %b want %b", c + 1, s_re, e_re[c]); end
            tests_run++; if (s_uv !== e_uv[c]) begin fails++; $display("FAIL stall uv cycle %0d: got %h want %h", c + 1, s_uv, e_uv[c]); end
            if (e_uv[c] != 8'h00) begin
                tests_run++; if (s_pay !== mkpay(e_id[c])) begin fails++; $display("FAIL stall payload cycle %0d: got %h want %h", c + 1, s_pay, mkpay(e_id[c])); end
            end
        end
    endtask

    task automatic test_illegal_code();
        bit         e_re  [6] = '{1, 1, 1, 0, 0, 0};
        bit         e_bad [6] = '{0, 0, 1, 1, 0, 0};
        logic [7:0] e_uv  [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
        dif.unitReady_i = 8'hFF;
        push_q(3'd5, 8); push_q(3'd7, 9); push_q(3'd2, 10);
        for (int c = 0; c < 6; c++) begin
            cyc();
            tests_run++; if (s_re !== e_re[c]) begin fails++; $display("FAIL illegal re cycle %0d: got %b want %b", c + 1, s_re, e_re[c]); end
            tests_run++; if (s_bad !== e_bad[c]) begin fails++; $display("FAIL illegal badUnit cycle %0d: got %b want %b", c + 1, s_bad, e_bad[c]); end
            tests_run++; if (s_uv !== e_uv[c]) begin fails++; $display("FAIL illegal uv cycle %0d: got %h want %h", c + 1, s_uv, e_uv[c]); end
            if (e_uv[c] != 8'h00) begin
                tests_run++; if (s_pay !== mkpay(10)) begin fails++; $display("FAIL illegal payload cycle %0d: got %h want %h", c + 1, s_pay, mkpay(10)); end
            end
        end
    endtask

    task automatic test_flush();
        bit         e_re [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        logic [7:0] e_uv [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00};
        int         e_id [9] = '{0, 0, 0, 0, 0, 0, 13, 14, 0};
        dif.unitReady_i = 8'hFF;
        push_q(3'd3, 11); push_q(3'd3, 12); push_q(3'd0, 13); push_q(3'd1, 14);
        for (int c = 0; c < 9; c++) begin
            dif.flush_i = (c == 2);
            cyc();
            tests_run++; if (s_re !== e_re[c]) begin fails++; $display("FAIL flush re cycle %0d: got %b want %b", c + 1, s_re, e_re[c]); end
            tests_run++; if (s_uv !== e_uv[c]) begin fails++; $display("FAIL flush uv cycle %0d: got %h want %h", c + 1, s_uv, e_uv[c]); end
            if (e_uv[c] != 8'h00) begin
                tests_run++; if (s_pay !== mkpay(e_id[c])) begin fails++; $display("FAIL flush payload cycle %0d: got %h want %h", c + 1, s_pay, mkpay(e_id[c])); end
            end
        end
        dif.flush_i = 1'b0;
    endtask

    task automatic test_empty();
        force_empty     = 1'b1;
        dif.unitReady_i = 8'hFF;
        push_q(3'd0, 20); push_q(3'd1, 21);
        for (int c = 0; c < 6; c++) begin
            cyc();
            tests_run++; if (s_re !== 1'b0) begin fails++; $display("FAIL empty re cycle %0d: got %b want 0", c + 1, s_re); end
            tests_run++; if (s_uv !== 8'h00) begin fails++; $display("FAIL empty uv cycle %0d: got %h want 00", c + 1, s_uv); end
        end
        force_empty = 1'b0;
        q_code.delete(); q_pay.delete();
        dif.isEmpty_i = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        bit         e_re [4] = '{1, 0, 0, 0};
        logic [7:0] e_uv [4] = '{8'h00, 8'h00, 8'h40, 8'h00};
        dif.unitReady_i = 8'hFF;
        push_q(3'd0, 15); push_q(3'd1, 16); push_q(3'd2, 17); push_q(3'd4, 18);
        repeat (3) cyc();
        tests_run++; if (s_uv !== 8'h01) begin fails++; $display("FAIL midreset pre uv: got %h want 01", s_uv); end
`ifdef IOQ_DISPATCH_STATS_EN
        tests_run++; if (dispatch_count !== 32'd11) begin fails++; $display("FAIL midreset pre dispatchCount: got %0d want 11", dispatch_count); end
`endif
        #2 reset_i = 1'b0;
        #1;
        tests_run++; if (dif.readEnable_o !== 1'b0) begin fails++; $display("FAIL midreset readEnable: got %b want 0", dif.readEnable_o); end
        tests_run++; if (dif.unitValid_o !== 8'h00) begin fails++; $display("FAIL midreset unitValid: got %h want 00", dif.unitValid_o); end
        tests_run++; if (dif.badUnit_o !== 1'b0) begin fails++; $display("FAIL midreset badUnit: got %b want 0", dif.badUnit_o); end
        tests_run++; if (dif.payload_o !== '0) begin fails++; $display("FAIL midreset payload: got %h want 0", dif.payload_o); end
`ifdef IOQ_DISPATCH_STATS_EN
        tests_run++; if (dispatch_count !== 32'd0) begin fails++; $display("FAIL midreset dispatchCount: got %0d want 0", dispatch_count); end
`endif
        q_code.delete(); q_pay.delete();
        dif.isEmpty_i = 1'b1;
        repeat (2) cyc();
        push_q(3'd6, 19);
        reset_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            tests_run++; if (s_re !== e_re[c]) begin fails++; $display("FAIL postreset re cycle %0d: got %b want %b", c + 1, s_re, e_re[c]); end
            tests_run++; if (s_uv !== e_uv[c]) begin fails++; $display("FAIL postreset uv cycle %0d: got %h want %h", c + 1, s_uv, e_uv[c]); end
            if (e_uv[c] != 8'h00) begin
                tests_run++; if (s_pay !== mkpay(19)) begin fails++; $display("FAIL postreset payload: got %h want %h", s_pay, mkpay(19)); end
            end
        end
`ifdef IOQ_DISPATCH_STATS_EN
        tests_run++; if (dispatch_count !== 32'd1) begin fails++; $display("FAIL postreset dispatchCount: got %0d want 1", dispatch_count); end
`endif
    endtask

    initial begin
        dif.isEmpty_i      = 1'b1;
        dif.payload_i      = '0;
        dif.funcUnitType_i = 3'd0;
        dif.flush_i        = 1'b0;
        dif.unitReady_i    = 8'h00;
        test_reset();
        test_in_order();
        test_stall();
        test_illegal_code();
        test_flush();
        test_empty();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
